// File: rtl/mux_rr_reg.sv
// mux_rr_reg: N-channel valid/ready multiplexer with fixed or round-robin
// grant feeding a one-entry registered output buffer.
//
// Ports:
//   clk, rst_n           clock, async active-low reset
//   in_data[N*WIDTH]     channel i word at [i*WIDTH +: WIDTH]
//   in_valid[N]          channel offers a word
//   in_ready[N]          channel word accepted this cycle (combinational)
//   mode                 0 = fixed select via sel, 1 = round-robin
//   sel[SELW]            channel index for fixed-select mode
//   out_data, out_ch     registered word and its source channel
//   out_valid            output buffer holds a word
//   out_ready            downstream accepts the word this cycle
module mux_rr_reg #(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    parameter int SELW  = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    input  logic               mode,
    input  logic [SELW-1:0]    sel,
    output logic [WIDTH-1:0]   out_data,
    output logic [SELW-1:0]    out_ch,
    output logic               out_valid,
    input  logic               out_ready
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t            state;
    logic [SELW-1:0]   ptr;
    logic [N-1:0]      gnt;
    logic [SELW-1:0]   g;
    logic              found;
    logic              load;
    logic              xfer;
    logic [WIDTH-1:0]  word;

    assign out_valid = (state == FULL);
    assign load      = !out_valid || out_ready;

    // Grant selection. Round-robin is done as two ordered passes:
    // first ptr..N-1, then 0..ptr-1, keeping the first hit.
    always_comb begin
        gnt   = '0;
        g     = '0;
        found = 1'b0;
        if (!mode) begin
            for (int i = 0; i < N; i++) begin
                if (int'(sel) == i && in_valid[i]) begin
                    gnt[i] = 1'b1;
                    g      = SELW'(i);
                    found  = 1'b1;
                end
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (!found && in_valid[i] && i >= int'(ptr)) begin
                    gnt[i] = 1'b1;
                    g      = SELW'(i);
                    found  = 1'b1;
                end
            end
            for (int i = 0; i < N; i++) begin
                if (!found && in_valid[i] && i < int'(ptr)) begin
                    gnt[i] = 1'b1;
                    g      = SELW'(i);
                    found  = 1'b1;
                end
            end
        end
    end

    // Only the granted channel's word is ever selected.
    always_comb begin
        word = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt[i]) begin
                word = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Ready is suppressed while reset is held so no handshake can be
    // observed upstream during reset.
    assign in_ready = gnt & {N{load & rst_n}};
    assign xfer     = found & load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= EMPTY;
            out_data <= '0;
            out_ch   <= '0;
            ptr      <= '0;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (xfer) begin
                        state    <= FULL;
                        out_data <= word;
                        out_ch   <= g;
                    end
                end
                FULL: begin
                    if (xfer) begin
                        state    <= FULL;
                        out_data <= word;
                        out_ch   <= g;
                    end else if (out_ready) begin
                        state <= EMPTY;
                    end
                end
                default: state <= EMPTY;
            endcase
            if (xfer && mode) begin
                ptr <= (int'(g) == N - 1) ? '0 : g + SELW'(1);
            end
        end
    end

endmodule

// File: tb/tb_mux_rr_reg.sv
// tb_mux_rr_reg: directed self-checking bench for mux_rr_reg
// (N=4, WIDTH=8, SELW=3 so out-of-range selects can be driven).
module tb_mux_rr_reg;

    localparam int WIDTH = 8;
    localparam int N     = 4;
    localparam int SELW  = 3;

    logic               clk;
    logic               rst_n;
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic               mode;
    logic [SELW-1:0]    sel;
    logic [WIDTH-1:0]   out_data;
    logic [SELW-1:0]    out_ch;
    logic               out_valid;
    logic               out_ready;

    int n_asrt = 0;
    int n_fail = 0;

    mux_rr_reg #(
        .WIDTH(WIDTH),
        .N    (N),
        .SELW (SELW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .mode     (mode),
        .sel      (sel),
        .out_data (out_data),
        .out_ch   (out_ch),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset: in_ready must stay low even with every channel valid.
        rst_n     = 1'b0;
        mode      = 1'b1;
        sel       = '0;
        in_valid  = 4'b1111;
        in_data   = 32'h13_12_11_10;
        out_ready = 1'b1;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_ch", out_ch, 0);
        chk("rst_in_ready", in_ready, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hold_valid", out_valid, 0);
        in_valid = '0;
        rst_n    = 1'b1;
        #1;

        // Fixed select, channel 2.
        mode     = 1'b0;
        sel      = 3'd2;
        in_valid = 4'b0100;
        in_data  = 32'h13_A5_11_10;
        #1;
        chk("fix_in_ready", in_ready, 4'b0100);
        cyc();
        chk("fix_out_valid", out_valid, 1);
        chk("fix_out_data", out_data, 8'hA5);
        chk("fix_out_ch", out_ch, 2);

        // No offer: drain, data and channel hold.
        in_valid = '0;
        #1;
        chk("drain_in_ready", in_ready, 0);
        cyc();
        chk("drain_valid", out_valid, 0);
        chk("drain_data", out_data, 8'hA5);
        chk("drain_ch", out_ch, 2);

        // Round-robin, all valid: 0,1,2,3,0 back to back.
        mode     = 1'b1;
        in_valid = 4'b1111;
        in_data  = 32'h13_12_11_10;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("rr_in_ready", in_ready, 4'b0001 << (k % 4));
            cyc();
            chk("rr_out_valid", out_valid, 1);
            chk("rr_out_ch", out_ch, k % 4);
            chk("rr_out_data", out_data, 8'h10 + (k % 4));
        end

        // ptr=1 now; grant ch2 to move ptr to 3, then wrap to ch0.
        in_valid = 4'b0100;
        #1;
        chk("pre_wrap_rdy", in_ready, 4'b0100);
        cyc();
        chk("pre_wrap_ch", out_ch, 2);
        in_valid = 4'b0011;
        #1;
        chk("wrap_rdy", in_ready, 4'b0001);
        cyc();
        chk("wrap_ch", out_ch, 0);
        chk("wrap_data", out_data, 8'h10);
        #1;
        chk("wrap_next_rdy", in_ready, 4'b0010);
        cyc();
        chk("wrap_next_ch", out_ch, 1);

        // FULL with backpressure: hold 3 cycles, then drain+reload.
        out_ready = 1'b0;
        in_valid  = 4'b1111;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_in_ready", in_ready, 0);
            cyc();
            chk("bp_valid", out_valid, 1);
            chk("bp_ch", out_ch, 1);
            chk("bp_data", out_data, 8'h11);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_rel_rdy", in_ready, 4'b0100);
        cyc();
        chk("bp_rel_valid", out_valid, 1);
        chk("bp_rel_ch", out_ch, 2);
        chk("bp_rel_data", out_data, 8'h12);

        // Fixed select out of range: nothing granted, buffer drains.
        mode = 1'b0;
        sel  = 3'd5;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("oor_in_ready", in_ready, 0);
            cyc();
            chk("oor_valid", out_valid, 0);
        end

        // Mode-0 transfer keeps ptr at 3; switching to mode 1 grants ch3.
        sel = 3'd1;
        #1;
        chk("m0_rdy", in_ready, 4'b0010);
        cyc();
        chk("m0_ch", out_ch, 1);
        mode = 1'b1;
        #1;
        chk("m1_rdy", in_ready, 4'b1000);
        cyc();
        chk("m1_ch", out_ch, 3);
        chk("m1_data", out_data, 8'h13);

        // Async reset while holding 3C: cleared immediately, ptr back to 0.
        in_valid = 4'b0001;
        in_data  = 32'h13_12_11_3C;
        cyc();
        chk("pre_rst_data", out_data, 8'h3C);
        in_valid  = '0;
        out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_data", out_data, 0);
        chk("arst_ch", out_ch, 0);
        #1;
        rst_n    = 1'b1;
        in_valid = 4'b1111;
        out_ready = 1'b1;
        #1;
        chk("post_rst_rdy", in_ready, 4'b0001);
        cyc();
        chk("post_rst_valid", out_valid, 1);
        chk("post_rst_ch", out_ch, 0);
        chk("post_rst_data", out_data, 8'h3C);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_asrt, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_rr_reg.md
MUX_RR_REG -- requirements
Module: mux_rr_reg

Interface
REQ-001 Parameter WIDTH, default 8, data width per channel in bits (>=1).
REQ-002 Parameter N, default 4, number of input channels (>=2).
REQ-003 Parameter SELW, default $clog2(N), width of channel index fields.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 in_data  input  N*WIDTH  channel i data at bits [i*WIDTH +: WIDTH].
REQ-007 in_valid  input  N  channel i offers a word.
REQ-008 in_ready  output  N  channel i word accepted this cycle (combinational).
REQ-009 mode  input  1  0 = fixed select, 1 = round-robin.
REQ-010 sel  input  SELW  channel index used in fixed-select mode.
REQ-011 out_data  output  WIDTH  registered output word.
REQ-012 out_ch  output  SELW  index of channel that supplied out_data.
REQ-013 out_valid  output  1  output register holds a word.
REQ-014 out_ready  input  1  downstream accepts the word this cycle.

Function
REQ-015 Output stage SHALL be a one-entry buffer with two states: EMPTY (out_valid=0), FULL (out_valid=1).
REQ-016 Load enable SHALL be: load = !out_valid | out_ready.
REQ-017 Mode 0: grant channel sel when sel<N and in_valid[sel]=1; sel>=N SHALL grant nothing.
REQ-018 Mode 1: grant the first channel with in_valid=1 searching ptr, ptr+1, ..., N-1, 0, ..., ptr-1 (wrap-around).
REQ-019 in_ready[g] SHALL equal load for granted channel g; all other in_ready bits 0; at most one in_ready bit high per cycle.
REQ-020 Transfer on channel g when in_valid[g] & in_ready[g]; next edge: out_data <= word g, out_ch <= g, out_valid <= 1.
REQ-021 Latency SHALL be exactly one cycle from input handshake to out_valid=1.
REQ-022 out_valid & out_ready with no new transfer SHALL clear out_valid next edge (FULL->EMPTY); out_data/out_ch hold last value.
REQ-023 Simultaneous drain and transfer SHALL replace the word in the same edge (FULL->FULL), giving one word per cycle throughput.
REQ-024 FULL with out_ready=0 SHALL hold out_data, out_ch, out_valid stable; all in_ready=0.
REQ-025 Round-robin pointer ptr (SELW bits) SHALL update only on a mode-1 transfer: ptr <= (g==N-1) ? 0 : g+1.
REQ-026 Mode-0 transfers SHALL leave ptr unchanged; mode change takes effect on the same cycle's combinational grant, ptr retained.
REQ-027 No valid channel (or invalid sel) SHALL produce no transfer; state unchanged apart from REQ-022 drain.
REQ-028 in_data of non-granted channels SHALL never reach out_data.

Reset
REQ-029 rst_n=0 SHALL asynchronously force out_valid=0, out_data=0, out_ch=0, ptr=0; in_ready=all-1-qualified-by-grant (load=1) during and after reset is not allowed: in_ready SHALL be 0 while rst_n=0.
REQ-030 Reset asserted mid-transfer SHALL discard the buffered word; first edge after release operates from EMPTY, ptr=0.

Verification
REQ-031 Reset then mode=0, sel=2, in_valid=4'b0100, in_data ch2=8'hA5, out_ready=1 -> in_ready=4'b0100; next edge out_valid=1, out_data=A5, out_ch=2.
REQ-032 mode=1, in_valid=4'b1111 held, out_ready=1, 5 cycles -> grants ch0,1,2,3,0 in order; one word per cycle.
REQ-033 mode=1, ptr=3, in_valid=4'b0011 -> grant ch0 (wrap), ptr becomes 1; next grant ch1.
REQ-034 FULL with out_ready=0 for 3 cycles while in_valid=4'b1111 -> in_ready=0, out_data/out_ch unchanged; out_ready=1 -> drain and reload same edge.
REQ-035 mode=0, sel=5 with N=4 (SELW=3 override) -> no in_ready ever high, out_valid stays 0.
REQ-036 rst_n pulled low asynchronously between edges while FULL (out_data=3C) -> out_valid=0, out_data=0 immediately; after release first transfer starts from ch0 in mode 1.
